// File: rtl/interrupt_controller_if.sv
// ============================================================================
//  Module      : interrupt_controller_if
//  Description : Peripheral raise/ack lines, processor request/ack and bus
//                address/control bundle for the interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interrupt_controller_if #(
    parameter int NUM_SOURCES = 2
);
    logic [7:0]             BUS_ADDR;
    logic                   BUS_WE;
    logic [NUM_SOURCES-1:0] IRQ_RAISE;
    logic [NUM_SOURCES-1:0] IRQ_ACK;
    logic                   CPU_INT_REQ;
    logic [2:0]             CPU_INT_ID;
    logic                   CPU_INT_ACK;

    modport master (
        output BUS_ADDR, BUS_WE, IRQ_RAISE, CPU_INT_ACK,
        input  IRQ_ACK, CPU_INT_REQ, CPU_INT_ID
    );

    modport slave (
        input  BUS_ADDR, BUS_WE, IRQ_RAISE, CPU_INT_ACK,
        output IRQ_ACK, CPU_INT_REQ, CPU_INT_ID
    );
endinterface

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
//  Module      : interrupt_controller
//  Description : Fixed-priority interrupt arbiter with memory-mapped mask,
//                pending and status registers on a shared 8-bit bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller #(
    parameter int         NUM_SOURCES    = 2,
    parameter logic [7:0] CTRL_BASE_ADDR = 8'hE0,
    parameter logic [7:0] INITIAL_MASK   = 8'hFF,
    parameter int         CLEAR_TIMEOUT  = 15
) (
    input  wire                 CLK,
    input  wire                 RESET,
    inout  wire  [7:0]          BUS_DATA,
    interrupt_controller_if.slave irq_bus
);

    localparam int CNT_W = $clog2(CLEAR_TIMEOUT + 2);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESENT    = 2'd1,
        ST_ACK        = 2'd2,
        ST_WAIT_CLEAR = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_req;
    logic                   w_req_nxt;
    logic [2:0]             r_id;
    logic [2:0]             w_id_nxt;
    logic [NUM_SOURCES-1:0] r_ack;
    logic [NUM_SOURCES-1:0] w_ack_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_set_timeout;

    logic [7:0]             r_mask;
    logic                   r_timeout_flag;
    logic                   r_tx;
    logic [1:0]             r_rd_sel;
    logic [7:0]             w_rd_data;

    logic [7:0]             w_addr_off;
    logic                   w_addr_hit;
    logic [NUM_SOURCES-1:0] w_pend_act;
    logic                   w_any;
    logic [2:0]             w_win_id;
    logic                   w_src_raised;
    logic [NUM_SOURCES-1:0] w_id_onehot;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    assign w_addr_off = irq_bus.BUS_ADDR - CTRL_BASE_ADDR;
    assign w_addr_hit = (w_addr_off < 8'd3);
    assign w_pend_act = irq_bus.IRQ_RAISE & r_mask[NUM_SOURCES-1:0];
    assign w_any      = |w_pend_act;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mask         <= INITIAL_MASK;
            r_timeout_flag <= 1'b0;
            r_tx           <= 1'b0;
            r_rd_sel       <= 2'd0;
        end else begin
            if (irq_bus.BUS_WE && (irq_bus.BUS_ADDR == CTRL_BASE_ADDR)) begin
                r_mask <= BUS_DATA;
            end
            // A timeout detected on the same edge as a clearing write wins,
            // so the event is never silently lost.
            if (w_set_timeout) begin
                r_timeout_flag <= 1'b1;
            end else if (irq_bus.BUS_WE && (irq_bus.BUS_ADDR == CTRL_BASE_ADDR + 8'd2)) begin
                r_timeout_flag <= 1'b0;
            end
            r_tx     <= w_addr_hit && !irq_bus.BUS_WE;
            r_rd_sel <= w_addr_off[1:0];
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (r_rd_sel)
            2'd0:    w_rd_data = r_mask;
            2'd1:    w_rd_data = 8'(w_pend_act);
            2'd2:    w_rd_data = {3'b000, r_req, r_id, r_timeout_flag};
            default: w_rd_data = 8'h00;
        endcase
    end

    assign BUS_DATA = r_tx ? w_rd_data : 8'bzzzz_zzzz;

    // ------------------------------------------------------------------
    // Arbitration: lowest index wins, so scan downwards and keep the last hit
    // ------------------------------------------------------------------
    always_comb begin
        w_win_id     = 3'd0;
        w_src_raised = 1'b0;
        w_id_onehot  = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (w_pend_act[i]) begin
                w_win_id = 3'(i);
            end
        end
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (r_id == 3'(i)) begin
                w_src_raised   = irq_bus.IRQ_RAISE[i];
                w_id_onehot[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Presentation / acknowledge state machine
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_id    <= 3'd0;
            r_ack   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_id    <= w_id_nxt;
            r_ack   <= w_ack_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_id_nxt      = r_id;
        w_ack_nxt     = '0;
        w_cnt_nxt     = r_cnt;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_req_nxt   = 1'b1;
                    w_id_nxt    = w_win_id;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (irq_bus.CPU_INT_ACK) begin
                    w_req_nxt   = 1'b0;
                    w_ack_nxt   = w_id_onehot;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR: begin
                // Holding here keeps a level-held raise from being presented twice.
                if (!w_src_raised) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(CLEAR_TIMEOUT)) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign irq_bus.IRQ_ACK     = r_ack;
    assign irq_bus.CPU_INT_REQ = r_req;
    assign irq_bus.CPU_INT_ID  = r_id;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
//  Module      : tb_interrupt_controller
//  Description : Directed stimulus with a queued scoreboard for the
//                interrupt controller's presentations, acks and bus reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    localparam logic [7:0] BASE = 8'hE0;
    localparam logic [1:0] K_PRES = 2'd0;
    localparam logic [1:0] K_ACK  = 2'd1;
    localparam logic [1:0] K_RD   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       drv_en;
    logic [7:0] drv_val;
    wire  [7:0] bus_data;

    int   vectors;
    int   miscompares;
    int   rd_req;
    int   rd_seen;
    int   ncyc;
    logic prev_req;
    exp_t sb[$];

    interrupt_controller_if #(.NUM_SOURCES(2)) ifc ();

    assign bus_data = drv_en ? drv_val : 8'bzzzz_zzzz;

    interrupt_controller #(
        .NUM_SOURCES   (2),
        .CTRL_BASE_ADDR(BASE),
        .INITIAL_MASK  (8'hFF),
        .CLEAR_TIMEOUT (15)
    ) dut (
        .CLK     (clk),
        .RESET   (rst),
        .BUS_DATA(bus_data),
        .irq_bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard whenever the DUT presents an output
    // ------------------------------------------------------------------
    task automatic check_evt(input logic [1:0] kind, input logic [7:0] val);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d val=%02h, required nothing", kind, val);
        end else begin
            e = sb.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                miscompares++;
                $display("FAIL event: got kind=%0d val=%02h, required kind=%0d val=%02h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.CPU_INT_REQ && !prev_req) check_evt(K_PRES, {5'b0, ifc.CPU_INT_ID});
            if (ifc.IRQ_ACK != 2'b00)         check_evt(K_ACK, {6'b0, ifc.IRQ_ACK});
            if (rd_req != rd_seen) begin
                check_evt(K_RD, bus_data);
                rd_seen++;
            end
        end
        prev_req = ifc.CPU_INT_REQ;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after a rising edge)
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        ifc.BUS_ADDR = addr;
        ifc.BUS_WE   = 1'b1;
        drv_val      = data;
        drv_en       = 1'b1;
        step(1);
        ifc.BUS_WE   = 1'b0;
        drv_en       = 1'b0;
        ifc.BUS_ADDR = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] addr, input logic [7:0] exp);
        push(K_RD, exp);
        ifc.BUS_ADDR = addr;
        ifc.BUS_WE   = 1'b0;
        step(1);
        ifc.BUS_ADDR = 8'h00;
        rd_req++;
        step(1);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!ifc.CPU_INT_REQ && n < 40) begin
            step(1);
            n++;
        end
        if (!ifc.CPU_INT_REQ) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_req: got CPU_INT_REQ=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic cpu_ack(input logic [1:0] src_mask, input logic [1:0] raise_after);
        push(K_ACK, {6'b0, src_mask});
        ifc.CPU_INT_ACK = 1'b1;
        step(1);
        ifc.CPU_INT_ACK = 1'b0;
        chk("req_after_ack", {7'b0, ifc.CPU_INT_REQ}, 8'h00);
        ifc.IRQ_RAISE = raise_after;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rd_req          = 0;
        rd_seen         = 0;
        prev_req        = 1'b0;
        drv_en          = 1'b0;
        drv_val         = 8'h00;
        ifc.BUS_ADDR    = 8'h00;
        ifc.BUS_WE      = 1'b0;
        ifc.IRQ_RAISE   = 2'b00;
        ifc.CPU_INT_ACK = 1'b0;
        rst             = 1'b1;
        #22;
        chk("reset_req", {7'b0, ifc.CPU_INT_REQ}, 8'h00);
        chk("reset_id",  {5'b0, ifc.CPU_INT_ID},  8'h00);
        chk("reset_ack", {6'b0, ifc.IRQ_ACK},     8'h00);
        step(1);
        rst = 1'b0;
        step(1);
        bus_read(BASE, 8'hFF);

        // Single source 1: present, ack, source drops
        ifc.IRQ_RAISE = 2'b10;
        push(K_PRES, 8'h01);
        wait_req(ncyc);
        chk("t1_latency", 8'(ncyc), 8'h01);
        cpu_ack(2'b10, 2'b00);
        step(3);
        bus_read(BASE + 8'd2, 8'h02);

        // Simultaneous raises: 0 first, then 1
        ifc.IRQ_RAISE = 2'b11;
        push(K_PRES, 8'h00);
        wait_req(ncyc);
        cpu_ack(2'b01, 2'b10);
        push(K_PRES, 8'h01);
        wait_req(ncyc);
        chk("t2_gap", 8'(ncyc), 8'h03);
        cpu_ack(2'b10, 2'b00);
        step(3);

        // Masked source stays quiet until re-enabled
        bus_write(BASE, 8'h01);
        ifc.IRQ_RAISE = 2'b10;
        step(5);
        chk("t3_masked_req", {7'b0, ifc.CPU_INT_REQ}, 8'h00);
        bus_read(BASE + 8'd1, 8'h00);
        push(K_PRES, 8'h01);
        bus_write(BASE, 8'h03);
        wait_req(ncyc);
        cpu_ack(2'b10, 2'b00);
        step(3);

        // CPU ack outside PRESENT is ignored
        ifc.CPU_INT_ACK = 1'b1;
        step(1);
        ifc.CPU_INT_ACK = 1'b0;
        step(2);
        chk("idle_ack_ignored", {6'b0, ifc.IRQ_ACK}, 8'h00);

        // Source holds raise past the clear timeout
        ifc.IRQ_RAISE = 2'b01;
        push(K_PRES, 8'h00);
        wait_req(ncyc);
        cpu_ack(2'b01, 2'b01);
        push(K_PRES, 8'h00);
        wait_req(ncyc);
        chk("t4_timeout_cycles", 8'(ncyc), 8'd18);
        bus_read(BASE + 8'd2, 8'h11);
        cpu_ack(2'b01, 2'b00);
        step(3);
        bus_write(BASE + 8'd2, 8'h00);
        bus_read(BASE + 8'd2, 8'h00);

        // Partial mask read-back and arbitration with source 0 disabled
        bus_write(BASE, 8'h5A);
        bus_read(BASE, 8'h5A);
        ifc.IRQ_RAISE = 2'b11;
        push(K_PRES, 8'h01);
        wait_req(ncyc);
        bus_read(BASE + 8'd1, 8'h02);
        cpu_ack(2'b10, 2'b00);
        step(3);
        bus_write(BASE, 8'hFF);

        // Asynchronous reset mid-PRESENT
        ifc.IRQ_RAISE = 2'b10;
        push(K_PRES, 8'h01);
        wait_req(ncyc);
        #4;
        rst           = 1'b1;
        ifc.IRQ_RAISE = 2'b00;
        #1;
        chk("async_reset_req", {7'b0, ifc.CPU_INT_REQ}, 8'h00);
        chk("async_reset_id",  {5'b0, ifc.CPU_INT_ID},  8'h00);
        step(1);
        rst = 1'b0;
        step(1);
        bus_read(BASE, 8'hFF);
        step(4);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing, required kind=%0d val=%02h", e.kind, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Interrupt-side counterpart to the bus peripherals. It receives BUS_INTERRUPT_RAISE lines from the peripherals (timer, mouse, and others) and returns the per-source BUS_INTERRUPT_ACK pulses to them.
- It arbitrates by fixed priority, presents one request plus its source ID to the processor, and converts the processor's acknowledge into a single-cycle ack to the winning source.
- Mask and status registers are memory-mapped on the shared 8-bit data bus.

Parameters:
- NumSources, 2, number of interrupt sources; legal range 1..8.
- CtrlBaseAddr, 8'hE0, base address of the controller's registers.
- InitialMask, 8'hFF, reset value of the enable mask; bits at or above NumSources are ignored.
- ClearTimeout, 15, maximum cycles to wait for the acked source to drop its raise line.

Ports:
- CLK  in  1  system clock. All logic uses rising edges.
- RESET  in  1  asynchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write enable.
- IRQ_RAISE  in  NumSources  raise lines from the peripherals; bit 0 has the highest priority.
- IRQ_ACK  out  NumSources  per-source acknowledge pulses to the peripherals.
- CPU_INT_REQ  out  1  interrupt request to the processor.
- CPU_INT_ID  out  3  index of the presented source.
- CPU_INT_ACK  in  1  processor acknowledge.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All registers clear immediately on RESET rising, independent of CLK.
  - Reset values: IRQ_ACK=0, CPU_INT_REQ=0, CPU_INT_ID=0, state=IDLE, Mask=InitialMask, TimeoutFlag=0, timeout counter=0.
  - BUS_DATA is high-Z during reset.
- Register map:
  - Base+0: Mask, read/write.
  - Base+1: Pending, read-only. Value = IRQ_RAISE & Mask, zero-extended to 8 bits.
  - Base+2: Status, read. Bit0 = TimeoutFlag, bits[3:1] = CPU_INT_ID, bit4 = CPU_INT_REQ. Any write to Base+2 clears TimeoutFlag.
- Writes: a register updates on the edge where BUS_WE=1 and its address matches.
- Reads:
  - A transmit flag is registered at each edge, set when BUS_ADDR matches Base+0..2 and BUS_WE=0.
  - While the flag is set, BUS_DATA combinationally drives the selected register's current value. Otherwise BUS_DATA is high-Z.
  - Read latency is one cycle.
- FSM states: IDLE, PRESENT, ACK, WAIT_CLEAR. All outputs are registered.
  - IDLE: if (IRQ_RAISE & Mask) is nonzero at an edge, latch the lowest set index into CPU_INT_ID, set CPU_INT_REQ=1, and go to PRESENT. A request is therefore visible one cycle after it is sampled.
  - PRESENT: hold CPU_INT_REQ and CPU_INT_ID stable. Mask writes and source deassertion do not withdraw a request once presented. On CPU_INT_ACK=1: CPU_INT_REQ←0, IRQ_ACK[CPU_INT_ID]←1, go to ACK.
  - ACK: IRQ_ACK returns to 0 at the next edge, so the pulse is exactly one cycle wide. Clear the timeout counter and go to WAIT_CLEAR.
  - WAIT_CLEAR:
    - If IRQ_RAISE[CPU_INT_ID]=0, go to IDLE.
    - Else, if the counter has reached ClearTimeout, set TimeoutFlag=1 and go to IDLE.
    - Else, increment the counter.
    - This state prevents the same level-held raise from being presented twice.
- CPU_INT_ACK is ignored outside PRESENT.
- At most one IRQ_ACK bit is ever high at a time.
- Simultaneous raises: the lowest index wins. The loser stays pending and is presented after WAIT_CLEAR→IDLE, with one IDLE cycle between presentations.
- Mask=0: nothing new is presented. Already-pending bits still read back 0 in Pending.
- A write to the Mask and a new raise at the same edge: arbitration uses the old Mask.
- RESET in any state: immediate return to IDLE. An in-flight ACK pulse is truncated.

Test Plan:
1. Reset, raise IRQ_RAISE[1] → CPU_INT_REQ=1 with CPU_INT_ID=1 one cycle later. Pulse CPU_INT_ACK, source drops its raise next cycle → IRQ_ACK=2'b10 for exactly one cycle, CPU_INT_REQ=0, FSM returns to IDLE.
2. Raise IRQ_RAISE=2'b11 in the same cycle → source 0 presented first. After ack and clear, source 1 is presented with CPU_INT_ID=1.
3. Write 8'h01 to Base+0, raise source 1 → no CPU_INT_REQ. Read Base+1 → 8'h00. Write 8'h03 → source 1 presented.
4. Source holds its raise after ack for 20 cycles with ClearTimeout=15 → return to IDLE after 16 WAIT_CLEAR cycles. Read Base+2 → bit0=1, then re-presentation follows. Write Base+2 → bit0=0.
5. Assert RESET asynchronously mid-PRESENT, between clock edges → CPU_INT_REQ falls without waiting for a clock edge. Mask reads back 8'hFF after release.
6. Read Base+0 with BUS_WE=0 → BUS_DATA carries Mask in the following cycle and is high-Z otherwise.
